// File: rtl/inst_encoder_loader.sv
// RV32I field-to-word encoder that streams packed
// instructions into instruction memory at sequential addresses.
module inst_encoder_loader #(
  parameter int WORD_BITWIDTH    = 32,
  parameter int REG_NUM_BITWIDTH = 5,
  parameter int ADDR_BITWIDTH    = 10,
  parameter int BASE_ADDR        = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        inValid,
  output logic                        inReady,
  input  logic [2:0]                  fmt,
  input  logic [2:0]                  funct3,
  input  logic [6:0]                  funct7,
  input  logic [REG_NUM_BITWIDTH-1:0] rd,
  input  logic [REG_NUM_BITWIDTH-1:0] rs1,
  input  logic [REG_NUM_BITWIDTH-1:0] rs2,
  input  logic [WORD_BITWIDTH-1:0]    imm,
  input  logic                        last,
  output logic                        memWrite,
  output logic [ADDR_BITWIDTH-1:0]    memAddr,
  output logic [WORD_BITWIDTH-1:0]    memWData,
  output logic [ADDR_BITWIDTH:0]      instCount,
  output logic                        error,
  output logic                        done
);

  localparam logic [ADDR_BITWIDTH-1:0] BASE =
    ADDR_BITWIDTH'(BASE_ADDR);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_J   = 7'b1101111;
  localparam logic [6:0] OP_U   = 7'b0110111;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_BITWIDTH-1:0] ptr;
  logic full;
  logic [WORD_BITWIDTH-1:0] word;
  logic legal;
  logic accept;
  logic do_write;
  logic session_start;

  logic is_r, is_i, is_s, is_b, is_j, is_u;
  logic fit12, fit13, fit21;

  assign is_r = (fmt == 3'd0);
  assign is_i = (fmt == 3'd1) || (fmt == 3'd2);
  assign is_s = (fmt == 3'd3);
  assign is_b = (fmt == 3'd4);
  assign is_j = (fmt == 3'd5);
  assign is_u = (fmt == 3'd6);

  // An immediate fits N signed bits when everything
  // above bit N-2 is a copy of the sign bit.
  assign fit12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fit13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fit21 = (&imm[31:20]) | ~(|imm[31:20]);

  // Pack fields per format and range-check the immediate.
  always_comb begin
    word  = '0;
    legal = 1'b0;
    unique case (1'b1)
      is_r: begin
        word  = {funct7, rs2, rs1, funct3, rd, OP_R};
        legal = 1'b1;
      end
      is_i: begin
        word  = {imm[11:0], rs1, funct3, rd,
                 (fmt == 3'd1) ? OP_LD : OP_IMM};
        legal = fit12;
      end
      is_s: begin
        word  = {imm[11:5], rs2, rs1, funct3,
                 imm[4:0], OP_S};
        legal = fit12;
      end
      is_b: begin
        word  = {imm[12], imm[10:5], rs2, rs1, funct3,
                 imm[4:1], imm[11], OP_B};
        legal = fit13 & ~imm[0];
      end
      is_j: begin
        word  = {imm[20], imm[10:1], imm[11],
                 imm[19:12], rd, OP_J};
        legal = fit21 & ~imm[0];
      end
      is_u: begin
        word  = {imm[31:12], rd, OP_U};
        legal = ~(|imm[11:0]);
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

  assign inReady       = (state == LOAD);
  assign accept        = inValid & inReady;
  assign session_start = (state == IDLE) & start;
  assign do_write      = accept & legal & ~full;

  // Session state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Session sequencing: one flush cycle after the last beat.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (accept && last) state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write port, pointer, counters and sticky error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      memWrite  <= 1'b0;
      memAddr   <= '0;
      memWData  <= '0;
      instCount <= '0;
      error     <= 1'b0;
      done      <= 1'b0;
      ptr       <= BASE;
      full      <= 1'b0;
    end else begin
      memWrite <= do_write;
      done     <= accept & last;
      if (session_start) begin
        ptr       <= BASE;
        instCount <= '0;
        error     <= 1'b0;
        full      <= 1'b0;
      end
      if (do_write) begin
        memAddr   <= ptr;
        memWData  <= word;
        instCount <= instCount + (ADDR_BITWIDTH+1)'(1);
        if (ptr == '1) full <= 1'b1;
        else           ptr  <= ptr + ADDR_BITWIDTH'(1);
      end
      if (accept && !do_write) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Bench for inst_encoder_loader: directed vectors plus
// randomized sessions against a session-level model.
module tb_inst_encoder_loader;

  localparam int AW  = 3;
  localparam int CAP = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, inValid, inReady, last;
  logic [2:0] fmt, funct3;
  logic [6:0] funct7;
  logic [4:0] rd, rs1, rs2;
  logic [31:0] imm;
  logic memWrite, error, done;
  logic [AW-1:0] memAddr;
  logic [31:0] memWData;
  logic [AW:0] instCount;

  inst_encoder_loader #(
    .WORD_BITWIDTH(32),
    .REG_NUM_BITWIDTH(5),
    .ADDR_BITWIDTH(AW),
    .BASE_ADDR(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .inValid(inValid),
    .inReady(inReady),
    .fmt(fmt),
    .funct3(funct3),
    .funct7(funct7),
    .rd(rd),
    .rs1(rs1),
    .rs2(rs2),
    .imm(imm),
    .last(last),
    .memWrite(memWrite),
    .memAddr(memAddr),
    .memWData(memWData),
    .instCount(instCount),
    .error(error),
    .done(done)
  );

  int n_chk = 0;
  int n_err = 0;

  // model: 0 idle, 1 loading, 2 flushing
  int m_mode = 0;
  int m_cnt = 0;
  bit m_err = 0;
  bit m_wr = 0;
  bit m_done = 0;
  int m_addr = 0;
  logic [31:0] m_data = '0;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_legal(int f, int v);
    case (f)
      0: return 1'b1;
      1, 2, 3: return v >= -2048 && v <= 2047;
      4: return v >= -4096 && v <= 4094 && (v % 2) == 0;
      5: return v >= -1048576 && v <= 1048574
                && (v % 2) == 0;
      6: return (v & 4095) == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int unsigned fld(int unsigned u,
                                      int hi, int lo);
    return (u >> lo) & ((32'd1 << (hi - lo + 1)) - 1);
  endfunction

  function automatic logic [31:0] m_enc(
    int f, int unsigned f3, int unsigned f7,
    int unsigned d, int unsigned s1, int unsigned s2,
    int unsigned u);
    int unsigned regs;
    regs = (s1 << 15) | (f3 << 12);
    case (f)
      0: return (f7 << 25) | (s2 << 20) | regs
                | (d << 7) | 51;
      1: return (fld(u, 11, 0) << 20) | regs | (d << 7) | 3;
      2: return (fld(u, 11, 0) << 20) | regs | (d << 7) | 19;
      3: return (fld(u, 11, 5) << 25) | (s2 << 20) | regs
                | (fld(u, 4, 0) << 7) | 35;
      4: return (fld(u, 12, 12) << 31) | (fld(u, 10, 5) << 25)
                | (s2 << 20) | regs | (fld(u, 4, 1) << 8)
                | (fld(u, 11, 11) << 7) | 99;
      5: return (fld(u, 20, 20) << 31) | (fld(u, 10, 1) << 21)
                | (fld(u, 11, 11) << 20)
                | (fld(u, 19, 12) << 12) | (d << 7) | 111;
      default: return (fld(u, 31, 12) << 12) | (d << 7) | 55;
    endcase
  endfunction

  task automatic model_edge();
    int v;
    v = imm;
    m_wr = 0;
    m_done = 0;
    if (!rst_n) begin
      m_mode = 0;
      m_cnt = 0;
      m_err = 0;
      m_addr = 0;
      m_data = '0;
    end else begin
      case (m_mode)
        0: if (start) begin
          m_mode = 1;
          m_cnt = 0;
          m_err = 0;
        end
        1: if (inValid) begin
          if (m_legal(int'(fmt), v) && m_cnt < CAP) begin
            m_wr = 1;
            m_addr = m_cnt;
            m_data = m_enc(int'(fmt), funct3, funct7,
                           rd, rs1, rs2, imm);
            m_cnt++;
          end else begin
            m_err = 1;
          end
          if (last) begin
            m_done = 1;
            m_mode = 2;
          end
        end
        default: m_mode = 0;
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("inReady", 32'(inReady), 32'(m_mode == 1));
    check("memWrite", 32'(memWrite), 32'(m_wr));
    check("memAddr", 32'(memAddr), 32'(m_addr));
    check("memWData", memWData, m_data);
    check("instCount", 32'(instCount), 32'(m_cnt));
    check("error", 32'(error), 32'(m_err));
    check("done", 32'(done), 32'(m_done));
  endtask

  task automatic set_beat(int f, int f3, int f7, int d,
                          int s1, int s2, int im, bit l);
    inValid = 1'b1;
    fmt = 3'(f);
    funct3 = 3'(f3);
    funct7 = 7'(f7);
    rd = 5'(d);
    rs1 = 5'(s1);
    rs2 = 5'(s2);
    imm = im;
    last = l;
  endtask

  task automatic do_start();
    inValid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  int bnd[14] = '{-2049, -2048, 2047, 2048, -4097, -4096,
                  4094, 4095, 4096, -1048577, -1048576,
                  1048574, 1048575, 1048576};

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    inValid = 1'b0;
    last = 1'b0;
    fmt = '0;
    funct3 = '0;
    funct7 = '0;
    rd = '0;
    rs1 = '0;
    rs2 = '0;
    imm = '0;
    step();
    step();
    check("rst_ready", 32'(inReady), 32'd0);
    check("rst_count", 32'(instCount), 32'd0);
    rst_n = 1'b1;
    step();

    // add, lw, beq in one session
    do_start();
    set_beat(0, 0, 0, 3, 1, 2, 0, 0);
    step();
    check("add_word", memWData, 32'h002081B3);
    check("add_addr", 32'(memAddr), 32'd0);
    set_beat(1, 2, 0, 5, 2, 0, -4, 0);
    step();
    check("lw_word", memWData, 32'hFFC12283);
    set_beat(4, 0, 0, 0, 1, 2, -8, 1);
    step();
    check("beq_word", memWData, 32'hFE208CE3);
    check("beq_done", 32'(done), 32'd1);
    inValid = 1'b0;
    step();
    check("flush_ready", 32'(inReady), 32'd0);
    step();

    // out-of-range immediate then a good add
    do_start();
    set_beat(2, 0, 0, 1, 1, 0, 2048, 0);
    step();
    check("bad_nowrite", 32'(memWrite), 32'd0);
    set_beat(0, 0, 0, 3, 1, 2, 0, 1);
    step();
    check("bad_error", 32'(error), 32'd1);
    check("bad_addr", 32'(memAddr), 32'd0);
    check("bad_count", 32'(instCount), 32'd1);
    inValid = 1'b0;
    step();
    step();

    // four back-to-back beats
    do_start();
    for (int i = 0; i < 4; i++) begin
      set_beat(2, 0, 0, i + 1, 0, 0, i * 3, i == 3);
      step();
      check("burst_addr", 32'(memAddr), 32'(i));
    end
    check("burst_done", 32'(done), 32'd1);
    check("burst_count", 32'(instCount), 32'd4);
    inValid = 1'b0;
    step();
    check("burst_ready", 32'(inReady), 32'd0);
    step();

    // overfill the memory
    do_start();
    for (int i = 0; i <= CAP; i++) begin
      set_beat(0, 0, 0, 3, 1, 2, 0, i == CAP);
      step();
    end
    check("full_write", 32'(memWrite), 32'd0);
    check("full_error", 32'(error), 32'd1);
    check("full_done", 32'(done), 32'd1);
    check("full_count", 32'(instCount), 32'(CAP));
    inValid = 1'b0;
    step();
    step();

    // reset right after an accept
    do_start();
    set_beat(0, 0, 0, 3, 1, 2, 0, 0);
    step();
    inValid = 1'b0;
    rst_n = 1'b0;
    step();
    check("mrst_write", 32'(memWrite), 32'd0);
    check("mrst_ready", 32'(inReady), 32'd0);
    check("mrst_error", 32'(error), 32'd0);
    check("mrst_count", 32'(instCount), 32'd0);
    rst_n = 1'b1;
    set_beat(0, 0, 0, 3, 1, 2, 0, 0);
    step();
    step();
    check("nostart_write", 32'(memWrite), 32'd0);

    // randomized sessions
    for (int c = 0; c < 4000; c++) begin
      int sel;
      int im;
      rst_n = ($urandom % 300) != 0;
      start = ($urandom % 6) == 0;
      sel = $urandom % 6;
      case (sel)
        0: im = $urandom;
        1: im = int'($urandom_range(0, 10000)) - 5000;
        2: im = bnd[$urandom % 14];
        3: im = $urandom & 32'hFFFFF000;
        4: im = (int'($urandom_range(0, 400)) - 200) * 2;
        default: im = int'($urandom_range(0, 2097152))
                      - 1048576;
      endcase
      set_beat($urandom % 8, $urandom % 8, $urandom % 128,
               $urandom % 32, $urandom % 32, $urandom % 32,
               im, ($urandom % 7) == 0);
      inValid = ($urandom % 4) != 0;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
